// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: UART command receiver plus response transmitter.
//   Receives two 8N1 bytes on RX (high byte first) and presents them as a
//   16-bit command with a ready flag. It also sends one 8N1 response byte on
//   TX on request. The receive and transmit paths run independently.
// Ports:
//   clk, rst     - rising-edge clock, synchronous active-high reset
//   RX / TX      - serial in / serial out, both idle high
//   cmd, cmd_rdy - assembled command and its valid flag
//   clr_cmd_rdy  - one-cycle acknowledge that clears cmd_rdy
//   resp, trmt   - response byte and one-cycle transmit request
//   tx_done      - last response frame has completed
module uart_cmd_responder #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);
    localparam int unsigned CNT_MIN  = 12;
    localparam int unsigned CNT_NEED = $clog2(BAUD_DIV + 1);
    localparam int unsigned CNT_W    = (CNT_NEED > CNT_MIN) ? CNT_NEED : CNT_MIN;
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(BAUD_DIV / 2);

    // ---------------- RX synchronizer and falling-edge detect ----------------
    logic       rx_ff1_q, rx_ff2_q, rx_prev_q;
    logic [1:0] warm_q;
    logic       rx_fall;

    // warm_q is saturated only once rx_ff2_q and rx_prev_q both hold real line
    // samples. This stops a line that is already low at reset release from
    // looking like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ff1_q  <= 1'b1;
            rx_ff2_q  <= 1'b1;
            rx_prev_q <= 1'b1;
            warm_q    <= 2'd0;
        end else begin
            rx_ff1_q  <= RX;
            rx_ff2_q  <= rx_ff1_q;
            rx_prev_q <= rx_ff2_q;
            if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
        end
    end

    assign rx_fall = (warm_q == 2'd3) && rx_prev_q && !rx_ff2_q;

    // ---------------- Receiver FSM ----------------
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic             byte_rdy_q, byte_rdy_d;
    logic             frm_err_q, frm_err_d;
    logic             rx_tick;

    // The counter fires on its last count (1). A reload of N therefore spans
    // exactly N cycles, and the counter holds at zero instead of wrapping.
    assign rx_tick = (rx_cnt_q <= CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            byte_rdy_q <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            byte_rdy_q <= byte_rdy_d;
            frm_err_q  <= frm_err_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        byte_rdy_d = 1'b0;
        frm_err_d  = 1'b0;
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - CNT_W'(1);
        case (rx_state_q)
            IDLE: begin
                if (rx_fall) begin
                    rx_state_d = START;
                    rx_cnt_d   = HALF_BIT;
                end
            end
            START: begin
                if (rx_tick) begin
                    if (!rx_ff2_q) begin
                        rx_state_d = DATA;
                        rx_cnt_d   = FULL_BIT;
                        rx_bit_d   = '0;
                    end else begin
                        rx_state_d = IDLE;      // glitch, not a real start bit
                    end
                end
            end
            DATA: begin
                if (rx_tick) begin
                    rx_sh_d  = {rx_ff2_q, rx_sh_q[7:1]};
                    rx_cnt_d = FULL_BIT;
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = STOP;
                end
            end
            STOP: begin
                if (rx_tick) begin
                    byte_rdy_d = rx_ff2_q;
                    frm_err_d  = !rx_ff2_q;
                    rx_state_d = IDLE;
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    // ---------------- Byte assembler ----------------
    typedef enum logic {WAIT_HI, WAIT_LO} asm_state_e;

    asm_state_e  asm_state_q, asm_state_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_state_q <= WAIT_HI;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
        end else begin
            asm_state_q <= asm_state_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
        end
    end

    // The clear is applied first so that a same-cycle set overrides it.
    always_comb begin
        asm_state_d = asm_state_q;
        cmd_d       = cmd_q;
        cmd_rdy_d   = cmd_rdy_q;
        if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
        case (asm_state_q)
            WAIT_HI: begin
                if (byte_rdy_q) begin
                    cmd_d[15:8] = rx_sh_q;
                    cmd_rdy_d   = 1'b0;
                    asm_state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (byte_rdy_q) begin
                    cmd_d[7:0]  = rx_sh_q;
                    cmd_rdy_d   = 1'b1;
                    asm_state_d = WAIT_HI;
                end else if (frm_err_q) begin
                    asm_state_d = WAIT_HI;
                end
            end
            default: asm_state_d = WAIT_HI;
        endcase
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;

    // ---------------- Transmitter FSM ----------------
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_e;

    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]       tx_bit_q, tx_bit_d;
    logic [8:0]       tx_sh_q, tx_sh_d;
    logic             tx_q, tx_d;
    logic             tx_done_q, tx_done_d;
    logic             tx_tick;

    assign tx_tick = (tx_cnt_q <= CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
        end
    end

    // The frame is {1, resp, 0}. The start bit goes straight into tx_q, and the
    // remaining nine bits wait in tx_sh_q to be shifted out LSB first.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_d       = tx_q;
        tx_done_d  = tx_done_q;
        if (tx_cnt_q != '0) tx_cnt_d = tx_cnt_q - CNT_W'(1);
        case (tx_state_q)
            TX_IDLE: begin
                if (trmt) begin
                    tx_sh_d    = {1'b1, resp};
                    tx_d       = 1'b0;
                    tx_done_d  = 1'b0;
                    tx_cnt_d   = FULL_BIT;
                    tx_bit_d   = '0;
                    tx_state_d = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_tick) begin
                    if (tx_bit_q == 4'd9) begin
                        tx_d       = 1'b1;
                        tx_done_d  = 1'b1;
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_d     = tx_sh_q[0];
                        tx_sh_d  = {1'b1, tx_sh_q[8:1]};
                        tx_bit_d = tx_bit_q + 4'd1;
                        tx_cnt_d = FULL_BIT;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign TX      = tx_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Testbench for uart_cmd_responder. A small bit period keeps the run short.
`timescale 1ns/1ps
module tb_uart_cmd_responder;
    localparam int unsigned B = 16;

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp_cmd;
    } cmd_vec_t;

    typedef struct {
        logic [7:0] resp;
        logic [9:0] exp_bits;   // line bits, index 0 = start bit
    } tx_vec_t;

    logic        clk = 1'b0;
    logic        rst, RX, TX, cmd_rdy, clr_cmd_rdy, trmt, tx_done;
    logic [15:0] cmd;
    logic [7:0]  resp;

    always #5 clk = ~clk;

    uart_cmd_responder #(.BAUD_DIV(B)) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .trmt        (trmt),
        .tx_done     (tx_done)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int rise_cyc = 0;
    int done_rises = 0;
    logic rdy_prev = 1'b0;
    logic done_prev = 1'b0;
    logic [15:0] cmd_exp_q[$];
    logic [7:0]  tx_exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        RX = b;
        tick(B);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic pulse_trmt(input logic [7:0] r);
        resp = r;
        trmt = 1'b1;
        tick(1);
        trmt = 1'b0;
    endtask

    task automatic wait_cmd_rdy(input string name);
        int n;
        n = 0;
        while (cmd_rdy !== 1'b1 && n < 25 * B) begin
            tick(1);
            n++;
        end
        check(name, cmd_rdy, 1);
    endtask

    task automatic clear_rdy();
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        check("cmd_rdy_cleared", cmd_rdy, 0);
    endtask

    // Command scoreboard: each rising edge of cmd_rdy consumes one expected command.
    always @(negedge clk) begin
        if (rst) begin
            rdy_prev <= 1'b0;
        end else begin
            if (cmd_rdy && !rdy_prev) begin
                rise_cyc <= cyc;
                if (cmd_exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL cmd_rdy_unexpected: got cmd 0x%04h, expected no cmd_rdy", cmd);
                end else begin
                    check("cmd_value", cmd, cmd_exp_q.pop_front());
                end
            end
            rdy_prev <= cmd_rdy;
        end
    end

    always @(negedge clk) begin
        if (tx_done && !done_prev) done_rises <= done_rises + 1;
        done_prev <= tx_done;
    end

    // Response receiver: decodes TX frames at mid-bit and checks them against the scoreboard.
    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && TX === 1'b0) begin
                repeat (B / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge clk);
                    b[i] = TX;
                end
                repeat (B) @(negedge clk);
                check("tx_stop_bit", TX, 1);
                if (tx_exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL tx_unexpected_frame: got 0x%02h, expected no frame", b);
                end else begin
                    check("tx_byte", b, tx_exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    cmd_vec_t cv[4];
    tx_vec_t  txv[5];

    initial begin : main
        int start_cyc;
        int rises0;
        cv[0] = '{8'h4B, 8'hF4, 16'h4BF4};
        cv[1] = '{8'h00, 8'hFF, 16'h00FF};
        cv[2] = '{8'hFF, 8'h00, 16'hFF00};
        cv[3] = '{8'hA5, 8'h5A, 16'hA55A};
        txv[0] = '{8'hA5, 10'b1_1010_0101_0};
        txv[1] = '{8'h00, 10'b1_0000_0000_0};
        txv[2] = '{8'hFF, 10'b1_1111_1111_0};
        txv[3] = '{8'h3C, 10'b1_0011_1100_0};
        txv[4] = '{8'h81, 10'b1_1000_0001_0};

        rst = 1'b1; RX = 1'b1; trmt = 1'b0; clr_cmd_rdy = 1'b0; resp = 8'h00;
        tick(4);
        check("rst_TX", TX, 1);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_cmd_rdy", cmd_rdy, 0);
        check("rst_tx_done", tx_done, 0);
        rst = 1'b0;
        tick(2);
        check("idle_TX", TX, 1);

        // Command pairs from the table
        for (int v = 0; v < 4; v++) begin
            cmd_exp_q.push_back(cv[v].exp_cmd);
            start_cyc = cyc;
            send_byte(cv[v].hi, 1'b1);
            send_byte(cv[v].lo, 1'b1);
            wait_cmd_rdy("cmd_rdy_set");
            if (v == 0)
                check("cmd_rdy_latency",
                      32'((rise_cyc - start_cyc) >= int'(19 * B) && (rise_cyc - start_cyc) <= int'(21 * B)), 1);
            tick(2 * B);
            check("cmd_rdy_hold", cmd_rdy, 1);
            check("cmd_stable", cmd, cv[v].exp_cmd);
            clear_rdy();
        end

        // Framing error on the low byte, then a good pair
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b0);
        send_bit(1'b1);
        check("no_rdy_bad_pair", cmd_rdy, 0);
        cmd_exp_q.push_back(16'h1234);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        wait_cmd_rdy("cmd_rdy_after_ferr");
        clear_rdy();

        // A clear held across the set cycle must lose to the set
        cmd_exp_q.push_back(16'hBEEF);
        clr_cmd_rdy = 1'b1;
        fork
            begin
                send_byte(8'hBE, 1'b1);
                send_byte(8'hEF, 1'b1);
            end
            begin
                int n;
                n = 0;
                while (cmd_rdy !== 1'b1 && n < 25 * B) begin
                    tick(1);
                    n++;
                end
                clr_cmd_rdy = 1'b0;
            end
        join
        check("set_wins_cmd_rdy", cmd_rdy, 1);
        clear_rdy();

        // Reset after a good high byte and four bits of the next frame
        send_byte(8'h77, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        rst = 1'b1;
        tick(3);
        RX = 1'b1;
        tick(2);
        rst = 1'b0;
        check("midrst_cmd", cmd, 16'h0000);
        check("midrst_cmd_rdy", cmd_rdy, 0);
        tick(2 * B);
        cmd_exp_q.push_back(16'h2900);
        send_byte(8'h29, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_cmd_rdy("cmd_rdy_after_midrst");
        clear_rdy();

        // Line already low when reset releases
        RX = 1'b0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2 * B);
        RX = 1'b1;
        tick(2 * B);
        check("rxlow_no_rdy", cmd_rdy, 0);
        cmd_exp_q.push_back(16'h3CC3);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hC3, 1'b1);
        wait_cmd_rdy("cmd_rdy_after_rxlow");
        clear_rdy();

        // Response frames from the table: every bit checked at mid-bit
        for (int v = 0; v < 5; v++) begin
            tx_exp_q.push_back(txv[v].resp);
            pulse_trmt(txv[v].resp);
            check("tx_start_next_cycle", TX, 0);
            check("tx_done_cleared", tx_done, 0);
            tick(B / 2);
            for (int k = 0; k < 10; k++) begin
                check($sformatf("tx_bit%0d_resp%02h", k, txv[v].resp), TX, txv[v].exp_bits[k]);
                if (k < 9) tick(B);
            end
            tick(B / 2 - 1);
            check("tx_done_not_early", tx_done, 0);
            tick(1);
            check("tx_done_set", tx_done, 1);
            check("tx_idle_after", TX, 1);
            tick(2);
        end

        // A trmt mid-frame must not disturb the frame in flight
        rises0 = done_rises;
        tx_exp_q.push_back(8'hA5);
        pulse_trmt(8'hA5);
        tick(3 * B);
        pulse_trmt(8'h5A);
        tick(7 * B - 2);
        check("retrig_done_not_early", tx_done, 0);
        tick(1);
        check("retrig_done_set", tx_done, 1);
        tick(2 * B);
        check("retrig_done_held", tx_done, 1);
        check("retrig_TX_idle", TX, 1);
        check("retrig_done_once", 32'(done_rises - rises0), 1);

        // Receive and transmit at the same time
        cmd_exp_q.push_back(16'h5EE5);
        tx_exp_q.push_back(8'h81);
        fork
            begin
                send_byte(8'h5E, 1'b1);
                send_byte(8'hE5, 1'b1);
            end
            begin
                tick(B);
                pulse_trmt(8'h81);
                tick(12 * B);
            end
        join
        wait_cmd_rdy("duplex_cmd_rdy");
        check("duplex_tx_done", tx_done, 1);
        clear_rdy();

        tick(2 * B);
        check("cmd_sb_empty", cmd_exp_q.size(), 0);
        check("tx_sb_empty", tx_exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_cmd_responder.md
UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 2604, giving clk cycles per UART bit (50 MHz / 19200 baud).
REQ-002 SHALL use one clock and a synchronous, active-high reset: port clk, input, 1, rising-edge system clock.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port RX, input, 1, asynchronous serial line from the remote initiator; idles high.
REQ-005 SHALL have port TX, output, 1, serial response line to the remote initiator; idles high.
REQ-006 SHALL have port cmd, output, 16, assembled command with the high byte received first.
REQ-007 SHALL have port cmd_rdy, output, 1, flag that a complete 16-bit command is valid.
REQ-008 SHALL have port clr_cmd_rdy, input, 1, one-cycle consumer acknowledge that clears cmd_rdy.
REQ-009 SHALL have port resp, input, 8, response byte, e.g. 0xA5 positive acknowledge.
REQ-010 SHALL have port trmt, input, 1, one-cycle request to transmit resp.
REQ-011 SHALL have port tx_done, output, 1, flag that the last response frame has completed.

Function
REQ-012 SHALL double-flop RX before use; the first flop resets to 1.
REQ-013 Receiver FSM SHALL have states IDLE, START, DATA, STOP.
REQ-014 IDLE->START on a synchronized RX falling edge; baud counter loads BAUD_DIV/2.
REQ-015 START SHALL resample RX at half-bit: 0 -> DATA with counter loaded to BAUD_DIV; 1 -> IDLE as a glitch, nothing captured.
REQ-016 DATA SHALL sample 8 bits, one per BAUD_DIV cycles, LSB first, shifted into an 8-bit register.
REQ-017 STOP SHALL sample RX after BAUD_DIV cycles: 1 = valid byte (pulse byte_rdy internally for 1 cycle); 0 = framing error, byte discarded; both -> IDLE.
REQ-018 Byte assembler SHALL have states WAIT_HI, WAIT_LO.
REQ-019 WAIT_HI, valid byte: latch into cmd[15:8], clear cmd_rdy, go to WAIT_LO.
REQ-020 WAIT_LO, valid byte: latch into cmd[7:0], set cmd_rdy the next cycle, go to WAIT_HI.
REQ-021 A framing error in either state SHALL return the assembler to WAIT_HI with cmd_rdy unchanged.
REQ-022 cmd SHALL be stable while cmd_rdy=1; cmd[15:8] changes only when a new high byte is accepted.
REQ-023 clr_cmd_rdy SHALL clear cmd_rdy on the next edge; if it coincides with the set, set wins.
REQ-024 Transmitter FSM SHALL have states TX_IDLE, TX_BUSY.
REQ-025 A trmt in TX_IDLE SHALL load the 10-bit frame {1, resp, 0}, clear tx_done, and go to TX_BUSY.
REQ-026 TX_BUSY SHALL shift TX LSB-first every BAUD_DIV cycles; the start bit appears on TX the cycle after trmt.
REQ-027 After 10 bit periods the transmitter SHALL go to TX_IDLE and set tx_done, held until the next accepted trmt.
REQ-028 A trmt during TX_BUSY SHALL be ignored; the frame in flight is unaffected.
REQ-029 Receiver and transmitter SHALL operate concurrently and independently (full duplex).
REQ-030 Baud counters SHALL be at least 12 bits, count down, and never wrap below zero.

Reset
REQ-031 On rst: TX=1, cmd=0x0000, cmd_rdy=0, tx_done=0, all FSMs in IDLE/WAIT_HI/TX_IDLE, counters and shift registers cleared.
REQ-032 A reset asserted mid-frame SHALL abort the frame; the partial byte and any latched high byte are discarded.
REQ-033 A frame already in progress on RX when rst deasserts SHALL be ignored until an idle-high followed by a falling edge is seen.

Verification
REQ-034 Initiator sends 0x4B then 0xF4 -> cmd=0x4BF4, cmd_rdy=1 about 20*BAUD_DIV cycles after the first start edge; stays 1 until clr_cmd_rdy.
REQ-035 trmt with resp=0xA5 -> TX bits 0,1,0,1,0,0,1,0,1,1, each BAUD_DIV cycles wide; tx_done=1 after the stop bit; the initiator receives 0xA5.
REQ-036 Second byte sent with stop bit 0, then 0x12,0x34 -> no cmd_rdy for the bad pair; cmd=0x1234 with cmd_rdy=1 afterwards.
REQ-037 clr_cmd_rdy issued on the same cycle cmd_rdy is set -> cmd_rdy=1.
REQ-038 rst pulsed after 4 data bits of a high byte, then 0x29,0x00 sent -> cmd=0x2900, cmd_rdy=1, no residue from the aborted frame.
REQ-039 trmt re-pulsed mid-frame with resp=0x5A -> TX still completes the original 0xA5 frame; tx_done rises exactly once.
